// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: upstream sequencer for the 12x9 LCD controller.
// Queues host commands in a small FIFO and buffers one full image.
// A command is issued only while the controller is idle. Load Data (cmd 0)
// streams the whole image on consecutive cycles.
// Optional feature macro: LCD_SEQ_TIMEOUT_EN adds a sticky busy watchdog
// (timeout_err); without it timeout_err is tied low.
module lcd_cmd_seq #(
    parameter int CMD_DEPTH   = 4,
    parameter int IMG_SIZE    = 108,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic       busy,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    output logic       seq_idle,
    output logic       timeout_err
);

    localparam int         PW       = $clog2(CMD_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(CMD_DEPTH);
    localparam logic [6:0] IMG_FULL = 7'(IMG_SIZE);
    localparam logic [6:0] IMG_LAST = 7'(IMG_SIZE - 1);

    // Reject parameter values the pointer and counter widths cannot represent.
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || IMG_SIZE < 1 ||
        IMG_SIZE > 127 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("lcd_cmd_seq: unsupported parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STREAM,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [2:0]    fifo_mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic [2:0]    head;
    logic          fifo_empty;
    logic          push;
    logic          launch;

    logic [7:0]    pix_buf [IMG_SIZE];
    logic [6:0]    pix_cnt;
    logic [6:0]    strm_idx;
    logic          img_full;
    logic          pix_wr;
    logic          strm_last;
    logic          timeout_hit;

    assign fifo_empty = (fifo_cnt == '0);
    assign host_ready = (fifo_cnt < DEPTH_C);
    assign head       = fifo_mem[rd_ptr];
    assign push       = host_valid && host_ready;

    assign img_full   = (pix_cnt == IMG_FULL);
    assign pix_ready  = (pix_cnt < IMG_FULL) && (state != ISSUE) && (state != STREAM);
    assign pix_wr     = pix_valid && pix_ready;
    assign strm_last  = (strm_idx == IMG_LAST);

    // A Load head waits for a complete image and blocks everything behind it.
    assign launch     = (state == IDLE) && !fifo_empty && !busy &&
                        ((head != 3'd0) || img_full);

    assign seq_idle   = (state == IDLE) && fifo_empty;

    // Next-state logic; the watchdog overrides every other transition.
    always_comb begin
        // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = ISSUE;
            ISSUE:   state_nxt = (cmd == 3'd0) ? STREAM : DRAIN;
            STREAM:  if (strm_last) state_nxt = DRAIN;
            DRAIN:   if (!busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timeout_hit) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Command FIFO pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (launch) rd_ptr <= rd_ptr + 1'b1;
            if (push && !launch)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (launch && !push) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Command FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the pointers and counts decide what is valid.
        if (push) fifo_mem[wr_ptr] <= host_cmd;
    end

    // Pixel buffer storage, written in raster order at pix_cnt.
    always_ff @(posedge clk) begin
        if (pix_wr) pix_buf[pix_cnt] <= pix_in;
    end

    // Pixel write index; cleared once an image has been streamed or on a watchdog abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                     pix_cnt <= '0;
        else if (timeout_hit || (state == STREAM && strm_last)) pix_cnt <= '0;
        else if (pix_wr)                                pix_cnt <= pix_cnt + 7'd1;
    end

    // Registered controller outputs: command pulse, command hold, streamed pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd       <= 3'd0;
            cmd_valid <= 1'b0;
            datain    <= 8'd0;
            strm_idx  <= 7'd0;
        end else begin
            cmd_valid <= launch;
            if (launch) cmd <= head;
            if (state == ISSUE && cmd == 3'd0) begin
                datain   <= pix_buf[0];
                strm_idx <= 7'd0;
            end else if (state == STREAM && !strm_last) begin
                datain   <= pix_buf[strm_idx + 7'd1];
                strm_idx <= strm_idx + 7'd1;
            end
        end
    end

`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wd_cnt;
    logic          wd_run;
    logic          wd_err;

    assign wd_run      = ((state == STREAM) || (state == DRAIN)) && busy;
    assign timeout_hit = wd_run && (wd_cnt == TW'(TIMEOUT_CYC - 1));
    assign timeout_err = wd_err;

    // Busy watchdog: counts busy cycles since the last issue; the error flag is sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (launch)      wd_cnt <= '0;
            else if (wd_run) wd_cnt <= wd_cnt + 1'b1;
            if (timeout_hit) wd_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
